// File: rtl/ready_valid_pkg.sv
// Shared helpers for the buffered ready/valid fork: power-of-two check,
// occupancy counter width and the statistics counter width.
package ready_valid_pkg;

  localparam int STAT_WIDTH = 32;

  function automatic bit is_pow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

  // Occupancy must represent 0..DEPTH inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/rv_fork_fifo.sv
// Single-channel synchronous FIFO for one fork output. Head entry is presented
// combinationally from the storage array; full/empty come from a registered count.
module rv_fork_fifo
  import ready_valid_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic                  full,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic                  empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = count_width(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  if (DEPTH < 2 || !is_pow2(DEPTH)) begin : g_bad_depth
    $error("rv_fork_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  w_do_push;
  logic                  w_do_pop;

  assign full      = (r_count == DEPTH_C);
  assign empty     = (r_count == '0);
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;
  assign head_data = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ready_valid_fork_buffered.sv
// Ready/valid broadcast with per-beat destination mask and a FIFO per output.
// Optional statistics counters are enabled by defining READY_VALID_FORK_STATS_EN.
module ready_valid_fork_buffered
  import ready_valid_pkg::*;
#(
  parameter int NUM_OUTPUTS = 2,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [DATA_WIDTH-1:0]             in_data,
  input  logic [NUM_OUTPUTS-1:0]            in_mask,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic [NUM_OUTPUTS*DATA_WIDTH-1:0] out_data,
  output logic [NUM_OUTPUTS-1:0]            out_valid,
  input  logic [NUM_OUTPUTS-1:0]            out_ready
`ifdef READY_VALID_FORK_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0]             stat_accepted,
  output logic [STAT_WIDTH-1:0]             stat_dropped,
  output logic [NUM_OUTPUTS*STAT_WIDTH-1:0] stat_stall
`endif
);

  if (NUM_OUTPUTS < 1) begin : g_bad_outputs
    $error("ready_valid_fork_buffered: NUM_OUTPUTS must be at least 1");
  end

  logic [NUM_OUTPUTS-1:0] w_full;
  logic [NUM_OUTPUTS-1:0] w_empty;
  logic [NUM_OUTPUTS-1:0] w_push;
  logic [NUM_OUTPUTS-1:0] w_pop;
  logic                   w_accept;

  // Ready is forced high while in reset so it never reflects stale full flags.
  assign in_ready  = rst | (&(~in_mask | ~w_full));
  assign w_accept  = in_valid & in_ready & ~rst;
  assign w_push    = {NUM_OUTPUTS{w_accept}} & in_mask;
  assign out_valid = ~w_empty;
  assign w_pop     = out_valid & out_ready;

  genvar gi;
  for (gi = 0; gi < NUM_OUTPUTS; gi++) begin : g_ch
    rv_fork_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (w_push[gi]),
      .push_data (in_data),
      .full      (w_full[gi]),
      .pop       (w_pop[gi]),
      .head_data (out_data[gi*DATA_WIDTH +: DATA_WIDTH]),
      .empty     (w_empty[gi])
    );
  end

`ifdef READY_VALID_FORK_STATS_EN
  logic [STAT_WIDTH-1:0] r_stat_accepted;
  logic [STAT_WIDTH-1:0] r_stat_dropped;

  assign stat_accepted = r_stat_accepted;
  assign stat_dropped  = r_stat_dropped;

  // All counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_accepted <= '0;
      r_stat_dropped  <= '0;
    end else if (w_accept) begin
      if (r_stat_accepted != '1) r_stat_accepted <= r_stat_accepted + 1'b1;
      if (in_mask == '0 && r_stat_dropped != '1) r_stat_dropped <= r_stat_dropped + 1'b1;
    end
  end

  for (gi = 0; gi < NUM_OUTPUTS; gi++) begin : g_stall
    logic [STAT_WIDTH-1:0] r_stat_stall;

    assign stat_stall[gi*STAT_WIDTH +: STAT_WIDTH] = r_stat_stall;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_stat_stall <= '0;
      end else if (in_valid && in_mask[gi] && w_full[gi] && r_stat_stall != '1) begin
        r_stat_stall <= r_stat_stall + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ready_valid_fork_buffered.sv
// Directed bench for ready_valid_fork_buffered (3 outputs, depth 4, 8-bit data).
// Statistics checks are compiled in only when READY_VALID_FORK_STATS_EN is defined.
module tb_ready_valid_fork_buffered;

  localparam int N  = 3;
  localparam int DW = 8;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] in_data;
  logic [N-1:0]  in_mask;
  logic          in_valid;
  logic          in_ready;
  logic [N*DW-1:0] out_data;
  logic [N-1:0]  out_valid;
  logic [N-1:0]  out_ready;
`ifdef READY_VALID_FORK_STATS_EN
  logic [31:0]   stat_accepted;
  logic [31:0]   stat_dropped;
  logic [N*32-1:0] stat_stall;
`endif

  int vectors = 0;
  int miscompares = 0;

  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  logic [DW-1:0] q2[$];

  always #5 clk = ~clk;

  ready_valid_fork_buffered #(
    .NUM_OUTPUTS (N),
    .DATA_WIDTH  (DW),
    .DEPTH       (D)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_mask   (in_mask),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef READY_VALID_FORK_STATS_EN
    ,
    .stat_accepted (stat_accepted),
    .stat_dropped  (stat_dropped),
    .stat_stall    (stat_stall)
`endif
  );

  // Record every delivered beat per channel.
  always @(posedge clk) begin
    if (!rst) begin
      if (out_valid[0] && out_ready[0]) q0.push_back(out_data[0*DW +: DW]);
      if (out_valid[1] && out_ready[1]) q1.push_back(out_data[1*DW +: DW]);
      if (out_valid[2] && out_ready[2]) q2.push_back(out_data[2*DW +: DW]);
    end
  end

  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_queues();
    q0.delete();
    q1.delete();
    q2.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_mask = '0; in_data = '0; out_ready = '0;
    step(2);
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++; $display("FAIL reset_in_ready_during: got %b want 1", in_ready);
    end
    vectors++;
    if (out_valid !== 3'b000) begin
      miscompares++; $display("FAIL reset_out_valid: got %b want 000", out_valid);
    end
    rst = 1'b0;
    step();
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++; $display("FAIL reset_in_ready_after: got %b want 1", in_ready);
    end
    $display("reset: in_ready=%b out_valid=%b", in_ready, out_valid);
  endtask

  task automatic test_broadcast();
    clear_queues();
    out_ready = 3'b111;
    in_data = 8'hA1; in_mask = 3'b111; in_valid = 1'b1;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 3'b000) begin
      miscompares++; $display("FAIL bcast_pre: got ready=%b valid=%b want 1/000", in_ready, out_valid);
    end
    step();
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 3'b111) begin
      miscompares++; $display("FAIL bcast_valid: got %b want 111", out_valid);
    end
    for (int c = 0; c < N; c++) begin
      vectors++;
      if (out_data[c*DW +: DW] !== 8'hA1) begin
        miscompares++; $display("FAIL bcast_data ch%0d: got %h want a1", c, out_data[c*DW +: DW]);
      end
    end
    step();
    vectors++;
    if (out_valid !== 3'b000) begin
      miscompares++; $display("FAIL bcast_drained: got %b want 000", out_valid);
    end
    $display("broadcast: 0xA1 mask 111");
  endtask

  task automatic test_selective();
    clear_queues();
    out_ready = 3'b111;
    in_data = 8'h10; in_mask = 3'b001; in_valid = 1'b1;
    step();
    in_data = 8'h20; in_mask = 3'b110;
    vectors++;
    if (out_valid !== 3'b001 || out_data[0 +: DW] !== 8'h10) begin
      miscompares++; $display("FAIL sel_first: got valid=%b d0=%h want 001/10", out_valid, out_data[0 +: DW]);
    end
    step();
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 3'b110 || out_data[DW +: DW] !== 8'h20 || out_data[2*DW +: DW] !== 8'h20) begin
      miscompares++; $display("FAIL sel_second: got valid=%b d1=%h d2=%h want 110/20/20",
                              out_valid, out_data[DW +: DW], out_data[2*DW +: DW]);
    end
    step(2);
    vectors++;
    if (q0.size() != 1 || q1.size() != 1 || q2.size() != 1 || q0[0] !== 8'h10 || q1[0] !== 8'h20 || q2[0] !== 8'h20) begin
      miscompares++; $display("FAIL sel_delivery: got sizes %0d/%0d/%0d want 1/1/1 with 10/20/20",
                              q0.size(), q1.size(), q2.size());
    end
    $display("selective: 0x10->ch0, 0x20->ch1,ch2");
  endtask

  task automatic test_zero_mask();
`ifdef READY_VALID_FORK_STATS_EN
    logic [31:0] acc0 = stat_accepted;
    logic [31:0] drp0 = stat_dropped;
`endif
    clear_queues();
    out_ready = 3'b111;
    in_data = 8'hEE; in_mask = 3'b000; in_valid = 1'b1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++; $display("FAIL zero_ready: got %b want 1", in_ready);
    end
    step();
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 3'b000) begin
      miscompares++; $display("FAIL zero_valid: got %b want 000", out_valid);
    end
`ifdef READY_VALID_FORK_STATS_EN
    vectors++;
    if (stat_accepted !== acc0 + 32'd1 || stat_dropped !== drp0 + 32'd1) begin
      miscompares++; $display("FAIL zero_stats: got acc=%0d drp=%0d want %0d/%0d",
                              stat_accepted, stat_dropped, acc0 + 1, drp0 + 1);
    end
`endif
    step();
    vectors++;
    if (out_valid !== 3'b000) begin
      miscompares++; $display("FAIL zero_valid_later: got %b want 000", out_valid);
    end
    $display("zero mask: beat discarded");
  endtask

  task automatic test_backpressure();
    clear_queues();
    out_ready = 3'b101;
    in_mask = 3'b111; in_valid = 1'b1;
    for (int b = 1; b <= 4; b++) begin
      in_data = DW'(b);
      vectors++;
      if (in_ready !== 1'b1) begin
        miscompares++; $display("FAIL bp_accept%0d: got ready=%b want 1", b, in_ready);
      end
      step();
    end
    in_data = 8'd5;
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++; $display("FAIL bp_full_ready: got %b want 0", in_ready);
    end
    step(3);
    vectors++;
    if (in_ready !== 1'b0 || q0.size() != 4 || q2.size() != 4 || q1.size() != 0) begin
      miscompares++; $display("FAIL bp_stalled: got ready=%b sizes %0d/%0d/%0d want 0 4/0/4",
                              in_ready, q0.size(), q1.size(), q2.size());
    end
    out_ready = 3'b111;
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++; $display("FAIL bp_no_comb_path: got %b want 0", in_ready);
    end
    step();
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++; $display("FAIL bp_ready_return: got %b want 1", in_ready);
    end
    step();
    in_data = 8'd6;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++; $display("FAIL bp_accept6: got %b want 1", in_ready);
    end
    step();
    in_valid = 1'b0;
    step(6);
    vectors++;
    if (q0.size() != 6 || q1.size() != 6 || q2.size() != 6) begin
      miscompares++; $display("FAIL bp_counts: got %0d/%0d/%0d want 6/6/6", q0.size(), q1.size(), q2.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        vectors++;
        if (q0[i] !== DW'(i + 1) || q1[i] !== DW'(i + 1) || q2[i] !== DW'(i + 1)) begin
          miscompares++; $display("FAIL bp_order[%0d]: got %0d/%0d/%0d want %0d", i, q0[i], q1[i], q2[i], i + 1);
        end
      end
    end
    $display("backpressure: beats 1..6 delivered to all channels");
  endtask

  task automatic test_full_pushpop();
    clear_queues();
    out_ready = 3'b110;
    in_mask = 3'b001; in_valid = 1'b1;
    for (int b = 0; b < 4; b++) begin
      in_data = DW'(8'h31 + b);
      step();
    end
    out_ready = 3'b111;
    in_data = 8'h35;
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++; $display("FAIL full_pop_ready: got %b want 0", in_ready);
    end
    step();
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++; $display("FAIL full_pop_next: got %b want 1", in_ready);
    end
    step();
    in_valid = 1'b0;
    step(6);
    vectors++;
    if (q0.size() != 5) begin
      miscompares++; $display("FAIL full_pop_count: got %0d want 5", q0.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        vectors++;
        if (q0[i] !== DW'(8'h31 + i)) begin
          miscompares++; $display("FAIL full_pop_order[%0d]: got %h want %h", i, q0[i], 8'h31 + i);
        end
      end
    end
    $display("full push/pop: 0x31..0x35 on ch0");
  endtask

  task automatic test_reset_mid();
    clear_queues();
    out_ready = 3'b000;
    in_mask = 3'b010; in_valid = 1'b1;
    for (int b = 0; b < 3; b++) begin
      in_data = DW'(8'h61 + b);
      step();
    end
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 3'b010) begin
      miscompares++; $display("FAIL rmid_buffered: got %b want 010", out_valid);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    vectors++;
    if (out_valid !== 3'b000 || in_ready !== 1'b1) begin
      miscompares++; $display("FAIL rmid_cleared: got valid=%b ready=%b want 000/1", out_valid, in_ready);
    end
    out_ready = 3'b111;
    in_data = 8'h55; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(3);
    vectors++;
    if (q1.size() != 1 || q1[0] !== 8'h55) begin
      miscompares++; $display("FAIL rmid_first: got size %0d head %h want 1/55", q1.size(), q1.size() ? q1[0] : 8'h00);
    end
    $display("reset mid-stream: first delivered 0x55");
  endtask

`ifdef READY_VALID_FORK_STATS_EN
  task automatic test_stats_saturation();
    out_ready = 3'b110;
    in_mask = 3'b001; in_valid = 1'b1;
    for (int b = 0; b < 4; b++) begin
      in_data = DW'(b);
      step();
    end
    dut.g_stall[0].r_stat_stall = 32'hFFFF_FFFE;
    step(3);
    vectors++;
    if (stat_stall[31:0] !== 32'hFFFF_FFFF) begin
      miscompares++; $display("FAIL stat_saturate: got %h want ffffffff", stat_stall[31:0]);
    end
    in_valid = 1'b0;
    out_ready = 3'b111;
    step(6);
    $display("stats: stall counter saturated");
  endtask
`endif

  initial begin
    test_reset();
    test_broadcast();
    test_selective();
    test_zero_mask();
    test_backpressure();
    test_full_pushpop();
    test_reset_mid();
`ifdef READY_VALID_FORK_STATS_EN
    test_stats_saturation();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
